// File: rtl/alu_writeback_stage_pkg.sv
// Shared PSR layout and condition-code definitions for the writeback stage, branch unit and decoder.
// Latency: n/a (types, constants and a pure combinational helper).
// Backpressure: n/a.
package alu_writeback_stage_pkg;

    // PSR bit positions, packed as {C,L,F,Z,N}
    localparam int PSR_W = 5;
    localparam int PSR_C = 4;
    localparam int PSR_L = 3;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 1;
    localparam int PSR_N = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_HI = 4'h4,
        COND_LS = 4'h5,
        COND_GT = 4'h6,
        COND_LE = 4'h7,
        COND_FS = 4'h8,
        COND_FC = 4'h9,
        COND_LO = 4'hA,
        COND_HS = 4'hB,
        COND_LT = 4'hC,
        COND_GE = 4'hD,
        COND_UC = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    // Evaluate a 4-bit condition code against a {C,L,F,Z,N} status word.
    function automatic logic cond_eval(input logic [PSR_W-1:0] psr_v, input logic [3:0] code);
        logic c, l, f, z, n;
        logic res;
        c = psr_v[PSR_C];
        l = psr_v[PSR_L];
        f = psr_v[PSR_F];
        z = psr_v[PSR_Z];
        n = psr_v[PSR_N];
        case (cond_e'(code))
            COND_EQ: res = z;
            COND_NE: res = !z;
            COND_CS: res = c;
            COND_CC: res = !c;
            COND_HI: res = l;
            COND_LS: res = !l;
            COND_GT: res = n;
            COND_LE: res = !n;
            COND_FS: res = f;
            COND_FC: res = !f;
            COND_LO: res = !l && !z;
            COND_HS: res = l || z;
            COND_LT: res = !n && !z;
            COND_GE: res = n || z;
            COND_UC: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_writeback_stage_wb_fifo.sv
// Generic DEPTH x W synchronous in-order FIFO with full/empty/count.
// Latency: 1 cycle from push to visibility at rdata; rdata shows the head combinationally.
// Backpressure: pushes while full and pops while empty are ignored; full/empty are registered-state only.
// Ports: clk/reset_n; push/wdata in; pop in, rdata out; full, empty, count status.
module wb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    // A full FIFO refuses the push even when a pop frees a slot the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointer increment wraps naturally
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU execute/writeback stage: buffers ALU results, drains to register file and masked PSR update.
// Latency: 1 cycle minimum from accept to rf_we (no empty bypass); PSR updates on the commit edge.
// Backpressure: in_ready = !full (registered state only); rf_stall holds the head entry in place.
// Ports: in_* valid/ready result channel; rf_stall/rf_we/rf_waddr/rf_wdata register-file port;
//        psr committed status, psr_pending flag-hazard hint, cond_code -> cond_true decode.
module alu_writeback_stage
    import alu_writeback_stage_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 2,
    parameter int REG_ADDR = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_result,
    input  logic [REG_ADDR-1:0] in_dest,
    input  logic                in_wr_en,
    input  logic [PSR_W-1:0]    in_flags,
    input  logic [PSR_W-1:0]    in_flag_mask,
    input  logic                rf_stall,
    output logic                rf_we,
    output logic [REG_ADDR-1:0] rf_waddr,
    output logic [WIDTH-1:0]    rf_wdata,
    output logic [PSR_W-1:0]    psr,
    input  logic [3:0]          cond_code,
    output logic                cond_true,
    output logic                psr_pending
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0]    result;
        logic [REG_ADDR-1:0] dest;
        logic                wr_en;
        logic [PSR_W-1:0]    flags;
        logic [PSR_W-1:0]    mask;
    } entry_t;

    entry_t        push_dat, head_dat;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          push, commit;
    logic [PSR_W-1:0] psr_q, psr_d;
    // Number of buffered entries that will touch the PSR when they commit
    logic [CW-1:0] pend_cnt_q, pend_cnt_d;

    assign push_dat = '{result: in_result, dest: in_dest, wr_en: in_wr_en,
                        flags: in_flags, mask: in_flag_mask};
    assign in_ready = !fifo_full;
    assign push     = in_valid && !fifo_full;
    assign commit   = !fifo_empty && !rf_stall;

    wb_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_wb_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (push_dat),
        .pop     (commit),
        .rdata   (head_dat),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        psr_d = psr_q;
        if (commit) begin
            for (int i = 0; i < PSR_W; i++) begin
                if (head_dat.mask[i]) psr_d[i] = head_dat.flags[i];
            end
        end
    end

    always_comb begin
        pend_cnt_d = pend_cnt_q;
        if (push && (|in_flag_mask))       pend_cnt_d = pend_cnt_d + 1'b1;
        if (commit && (|head_dat.mask))    pend_cnt_d = pend_cnt_d - 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            psr_q      <= '0;
            pend_cnt_q <= '0;
        end else begin
            psr_q      <= psr_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign rf_we       = commit && head_dat.wr_en;
    assign rf_waddr    = head_dat.dest;
    assign rf_wdata    = head_dat.result;
    assign psr         = psr_q;
    assign psr_pending = (pend_cnt_q != '0);
    assign cond_true   = cond_eval(psr_q, cond_code);

    // Occupancy can never exceed the buffer size.
    a_count_bound: assert property (@(posedge clk) disable iff (!reset_n)
        fifo_count <= CW'(DEPTH));

endmodule
